// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/serial_adder_fa.sv
// Gate-level one-bit full adder cell used by the serial adder datapath.
module structuralFullAdder (
  input  logic a,
  input  logic b,
  input  logic carryin,
  output logic sum,
  output logic carryout
);

  logic axb;
  logic gen;
  logic prop;

  xor x_half (axb, a, b);
  xor x_sum  (sum, axb, carryin);
  and a_gen  (gen, a, b);
  and a_prop (prop, axb, carryin);
  or  o_cout (carryout, gen, prop);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one operand bit per RUN cycle through a gate-level full adder,
// result presented after WIDTH cycles with a one-cycle done pulse.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryout
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             carry;
  logic [CW-1:0]    count;
  logic             s_bit;
  logic             c_bit;

  structuralFullAdder u_fa (
    .a        (a_sr[0]),
    .b        (b_sr[0]),
    .carryin  (carry),
    .sum      (s_bit),
    .carryout (c_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      carry    <= 1'b0;
      count    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      carryout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= carryin;
            count <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          res_sr <= {s_bit, res_sr[WIDTH-1:1]};
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          carry  <= c_bit;
          count  <= count + CW'(1);
          // Final bit is taken straight from the cell so sum lands on this same edge.
          if (count == LAST) begin
            sum      <= {s_bit, res_sr[WIDTH-1:1]};
            carryout <= c_bit;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed corner cases plus random operands
// compared against an arithmetic reference of {carryout, sum}.
module tb_serial_adder;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         carryin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carryout;

  int tests = 0;
  int fails = 0;
  logic [W:0] prev_res = '0;

  serial_adder #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .carryin  (carryin),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .carryout (carryout)
  );

  initial begin
    clk = 1'b0;
    forever #500 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the DONE->IDLE edge so the
  // next call issues at the maximum back-to-back rate.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                        input bit reissue);
    logic [W:0] expv;
    expv = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    start = 1'b1; a = x; b = y; carryin = ci;
    @(negedge clk);
    start = 1'b0; a = W'($urandom); b = W'($urandom); carryin = 1'($urandom);
    for (int i = 0; i < int'(W); i++) begin
      check("busy_run", 32'(busy), 32'd1);
      check("done_run", 32'(done), 32'd0);
      check("hold_run", 32'({carryout, sum}), 32'(prev_res));
      if (reissue && i == 2) begin
        start = 1'b1; a = 8'h01; b = 8'h01;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("done_pulse", 32'(done), 32'd1);
    check("busy_done", 32'(busy), 32'd0);
    check("result", 32'({carryout, sum}), 32'(expv));
    prev_res = expv;
    @(negedge clk);
    check("done_clear", 32'(done), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    check(tag, 32'({busy, done, carryout, sum}), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b1; a = 8'hAA; b = 8'h55; carryin = 1'b1;
    repeat (2) @(negedge clk);
    check_zero("reset_state");
    rst_n = 1'b1;
    run_op(8'h35, 8'h4A, 1'b0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b1, 1'b0);
    run_op(8'h00, 8'h00, 1'b0, 1'b0);
    run_op(8'h12, 8'h34, 1'b1, 1'b1);

    // Abort after three RUN cycles; outputs must clear without waiting for a clock.
    start = 1'b1; a = 8'h77; b = 8'h66; carryin = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    start = 1'b1;
    @(negedge clk);
    check_zero("reset_hold");
    rst_n = 1'b1;
    prev_res = '0;
    run_op(8'h10, 8'h20, 1'b1, 1'b0);

    for (int n = 0; n < 300; n++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), bit'($urandom_range(0, 7) == 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
